// File: rtl/register_bank.sv
// register_bank: CPU-side register file with 16 general registers and a 4-bit flag register.
//
// Register PCIndex doubles as the program counter. It can be advanced by PCStep, overwritten by
// a write, or overwritten by a MOV. Reads have one cycle of latency. A read that hits the same
// cycle's write or MOV destination returns the new data.
//
// Ports:
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   writeEnable         write strobe
//   writeRegister       write destination index
//   writeValue          write data
//   movEnable           MOV strobe
//   MOVRegisterOrigin   MOV source index
//   MOVRegisterDestiny  MOV destination index
//   readEnable          read request
//   readRegister        read index
//   readValue           registered read data
//   readValid           one-cycle pulse qualifying readValue
//   pcIncrement         advance R[PCIndex] by PCStep
//   PC_Read             R[PCIndex], straight from the register
//   flagsWrite          capture Flags
//   Flags               ALU flags {N,Z,C,V}
//   Flags_Read          stored flags
//
// Optional feature: define REGISTER_BANK_ZERO_REG_EN to hardwire R0 to zero.

module register_bank #(
    parameter int unsigned RegisterSize      = 32,
    parameter int unsigned AmountOfRegisters = 16,
    parameter int unsigned PCIndex           = 15,
    parameter int unsigned PCStep            = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    writeEnable,
    input  logic [3:0]              writeRegister,
    input  logic [RegisterSize-1:0] writeValue,
    input  logic                    movEnable,
    input  logic [3:0]              MOVRegisterOrigin,
    input  logic [3:0]              MOVRegisterDestiny,
    input  logic                    readEnable,
    input  logic [3:0]              readRegister,
    output logic [RegisterSize-1:0] readValue,
    output logic                    readValid,
    input  logic                    pcIncrement,
    output logic [RegisterSize-1:0] PC_Read,
    input  logic                    flagsWrite,
    input  logic [3:0]              Flags,
    output logic [3:0]              Flags_Read
);

    localparam logic [3:0]              PcIdx  = 4'(PCIndex);
    localparam logic [RegisterSize-1:0] PcStep = RegisterSize'(PCStep);

    logic [RegisterSize-1:0] regs_q [AmountOfRegisters];
    logic [RegisterSize-1:0] regs_d [AmountOfRegisters];
    logic [RegisterSize-1:0] rd_data;

    // Later assignments override earlier ones, giving PC priority write > MOV > increment and
    // letting a write beat a MOV to the same destination. Sources always read pre-edge values.
    always_comb begin
        regs_d = regs_q;
        if (pcIncrement) begin
            regs_d[PcIdx] = regs_q[PcIdx] + PcStep;
        end
        if (movEnable) begin
            regs_d[MOVRegisterDestiny] = regs_q[MOVRegisterOrigin];
        end
        if (writeEnable) begin
            regs_d[writeRegister] = writeValue;
        end
`ifdef REGISTER_BANK_ZERO_REG_EN
        regs_d[0] = '0;
`endif
    end

    // Read bypass covers the write and MOV destinations only, not the PC increment.
    always_comb begin
        rd_data = regs_q[readRegister];
        if (movEnable && (MOVRegisterDestiny == readRegister)) begin
            rd_data = regs_q[MOVRegisterOrigin];
        end
        if (writeEnable && (writeRegister == readRegister)) begin
            rd_data = writeValue;
        end
`ifdef REGISTER_BANK_ZERO_REG_EN
        if (readRegister == 4'd0) begin
            rd_data = '0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < AmountOfRegisters; i++) begin
                regs_q[i] <= '0;
            end
            readValue  <= '0;
            readValid  <= 1'b0;
            Flags_Read <= 4'b0;
        end else begin
            regs_q    <= regs_d;
            readValid <= readEnable;
            if (readEnable) begin
                readValue <= rd_data;
            end
            if (flagsWrite) begin
                Flags_Read <= Flags;
            end
        end
    end

    assign PC_Read = regs_q[PcIdx];

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: scoreboard bench for register_bank. A reference model predicts each read
// result when the read is issued; the prediction is queued and compared when readValid arrives.

module tb_register_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        writeEnable;
    logic [3:0]  writeRegister;
    logic [31:0] writeValue;
    logic        movEnable;
    logic [3:0]  MOVRegisterOrigin;
    logic [3:0]  MOVRegisterDestiny;
    logic        readEnable;
    logic [3:0]  readRegister;
    logic [31:0] readValue;
    logic        readValid;
    logic        pcIncrement;
    logic [31:0] PC_Read;
    logic        flagsWrite;
    logic [3:0]  Flags;
    logic [3:0]  Flags_Read;

    int unsigned n_vectors = 0;
    int unsigned n_errors  = 0;

    logic [31:0] model_regs [16];
    logic [3:0]  model_flags;
    logic [31:0] exp_q [$];

    always #5 clk = ~clk;

    register_bank dut (
        .clk                (clk),
        .reset              (reset),
        .writeEnable        (writeEnable),
        .writeRegister      (writeRegister),
        .writeValue         (writeValue),
        .movEnable          (movEnable),
        .MOVRegisterOrigin  (MOVRegisterOrigin),
        .MOVRegisterDestiny (MOVRegisterDestiny),
        .readEnable         (readEnable),
        .readRegister       (readRegister),
        .readValue          (readValue),
        .readValid          (readValid),
        .pcIncrement        (pcIncrement),
        .PC_Read            (PC_Read),
        .flagsWrite         (flagsWrite),
        .Flags              (Flags),
        .Flags_Read         (Flags_Read)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        writeEnable        = 1'b0;
        writeRegister      = 4'd0;
        writeValue         = 32'd0;
        movEnable          = 1'b0;
        MOVRegisterOrigin  = 4'd0;
        MOVRegisterDestiny = 4'd0;
        readEnable         = 1'b0;
        readRegister       = 4'd0;
        pcIncrement        = 1'b0;
        flagsWrite         = 1'b0;
        Flags              = 4'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
        model_flags = 4'd0;
        exp_q.delete();
    endtask

    // Predict the read result, update the model, clock once and check the outputs.
    task automatic step();
        logic [31:0] nxt [16];
        logic [31:0] exp;
        logic [31:0] popped;
        bit          rd;
        rd = readEnable;
        if (readEnable) begin
            exp = model_regs[readRegister];
            if (movEnable && MOVRegisterDestiny == readRegister) exp = model_regs[MOVRegisterOrigin];
            if (writeEnable && writeRegister == readRegister) exp = writeValue;
`ifdef REGISTER_BANK_ZERO_REG_EN
            if (readRegister == 4'd0) exp = 32'd0;
`endif
            exp_q.push_back(exp);
        end
        nxt = model_regs;
        if (pcIncrement) nxt[15] = model_regs[15] + 32'd4;
        if (movEnable && !(writeEnable && writeRegister == MOVRegisterDestiny))
            nxt[MOVRegisterDestiny] = model_regs[MOVRegisterOrigin];
        if (writeEnable) nxt[writeRegister] = writeValue;
`ifdef REGISTER_BANK_ZERO_REG_EN
        nxt[0] = 32'd0;
`endif
        if (flagsWrite) model_flags = Flags;
        model_regs = nxt;

        @(posedge clk);
        #1;
        check("readValid", {31'd0, readValid}, {31'd0, rd});
        if (rd) begin
            if (exp_q.size() == 0) begin
                check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                popped = exp_q.pop_front();
                check("readValue", readValue, popped);
            end
        end
        check("PC_Read", PC_Read, model_regs[15]);
        check("Flags_Read", {28'd0, Flags_Read}, {28'd0, model_flags});
        idle_inputs();
    endtask

    task automatic do_write(input logic [3:0] r, input logic [31:0] v);
        writeEnable   = 1'b1;
        writeRegister = r;
        writeValue    = v;
    endtask

    task automatic do_read(input logic [3:0] r);
        readEnable   = 1'b1;
        readRegister = r;
    endtask

    task automatic do_mov(input logic [3:0] src, input logic [3:0] dst);
        movEnable          = 1'b1;
        MOVRegisterOrigin  = src;
        MOVRegisterDestiny = dst;
    endtask

    initial begin
        idle_inputs();
        model_reset();
        reset = 1'b0;
        // Strobes during reset must be ignored.
        do_write(4'd3, 32'hFFFF_FFFF);
        pcIncrement = 1'b1;
        flagsWrite  = 1'b1;
        Flags       = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("rst_readValid", {31'd0, readValid}, 32'd0);
        check("rst_readValue", readValue, 32'd0);
        check("rst_PC", PC_Read, 32'd0);
        check("rst_flags", {28'd0, Flags_Read}, 32'd0);
        idle_inputs();
        reset = 1'b1;

        // Reset then read R5.
        do_read(4'd5);
        step();
        check("R5_after_reset", readValue, 32'd0);

        // Write R3, read back; same-cycle write+read bypass on R7.
        do_write(4'd3, 32'h0000_002A);
        step();
        do_read(4'd3);
        step();
        check("R3_const", readValue, 32'h0000_002A);
        do_write(4'd7, 32'h11);
        do_read(4'd7);
        step();
        check("R7_bypass_const", readValue, 32'h11);

        // MOV 2->9, source untouched, self-MOV no-op; MOV-destination bypass.
        do_write(4'd2, 32'hDEAD_BEEF);
        step();
        do_mov(4'd2, 4'd9);
        step();
        do_read(4'd9);
        step();
        check("R9_const", readValue, 32'hDEAD_BEEF);
        do_read(4'd2);
        step();
        do_mov(4'd9, 4'd9);
        step();
        do_read(4'd9);
        step();
        do_mov(4'd3, 4'd10);
        do_read(4'd10);
        step();

        // Write wins over MOV to same destination; MOV from written register copies old value.
        do_write(4'd4, 32'h5);
        do_mov(4'd2, 4'd4);
        step();
        do_read(4'd4);
        step();
        check("R4_const", readValue, 32'h5);
        do_write(4'd2, 32'h1234_5678);
        do_mov(4'd2, 4'd11);
        step();
        do_read(4'd11);
        step();
        check("R11_old_value", readValue, 32'hDEAD_BEEF);

        // Write to PC beats increment; MOV to PC beats increment.
        do_write(4'd15, 32'h100);
        pcIncrement = 1'b1;
        step();
        check("PC_write_wins", PC_Read, 32'h100);
        do_mov(4'd4, 4'd15);
        pcIncrement = 1'b1;
        step();
        check("PC_mov_wins", PC_Read, 32'h5);

        // PC wrap-around.
        do_write(4'd15, 32'hFFFF_FFFC);
        step();
        pcIncrement = 1'b1;
        step();
        check("PC_wrap", PC_Read, 32'h0);
        for (int i = 0; i < 3; i++) begin
            pcIncrement = 1'b1;
            step();
        end
        check("PC_after_3", PC_Read, 32'h0000_000C);

        // Flags capture and hold.
        flagsWrite = 1'b1;
        Flags      = 4'b1010;
        step();
        check("flags_const", {28'd0, Flags_Read}, 32'hA);
        Flags = 4'b0101;
        step();

        // Back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i));
            step();
        end

        // Random mix of operations against the model.
        for (int i = 0; i < 60; i++) begin
            writeEnable        = 1'($urandom_range(0, 1));
            writeRegister      = 4'($urandom_range(0, 15));
            writeValue         = $urandom;
            movEnable          = 1'($urandom_range(0, 1));
            MOVRegisterOrigin  = 4'($urandom_range(0, 15));
            MOVRegisterDestiny = 4'($urandom_range(0, 15));
            readEnable         = 1'($urandom_range(0, 1));
            readRegister       = 4'($urandom_range(0, 15));
            pcIncrement        = 1'($urandom_range(0, 1));
            flagsWrite         = 1'($urandom_range(0, 1));
            Flags              = 4'($urandom_range(0, 15));
            step();
        end

        // Make state nonzero, then assert reset mid-cycle with a read pending.
        do_write(4'd15, 32'h40);
        flagsWrite = 1'b1;
        Flags      = 4'b1010;
        step();
        do_read(4'd15);
        step();
        do_read(4'd3);
        #2;
        reset = 1'b0;
        #1;
        check("async_flags", {28'd0, Flags_Read}, 32'd0);
        check("async_readValid", {31'd0, readValid}, 32'd0);
        check("async_readValue", readValue, 32'd0);
        check("async_PC", PC_Read, 32'd0);
        @(posedge clk);
        #1;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        step();
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i));
            step();
            check("post_reset_reg", readValue, 32'd0);
        end

        // R0 handling: hardwired zero when the feature is enabled.
        do_write(4'd0, 32'h55);
        step();
        do_read(4'd0);
        step();
`ifdef REGISTER_BANK_ZERO_REG_EN
        check("R0_zero", readValue, 32'd0);
`else
        check("R0_store", readValue, 32'h55);
`endif
        do_write(4'd0, 32'h66);
        do_read(4'd0);
        step();

        if (exp_q.size() != 0) check("scoreboard_leftover", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
